// File: rtl/pixel_seq_ctrl.sv
// Frame sequencer driving pixel-array erase/expose/convert/read lines and the readout address.
// Optional PIXEL_SEQ_FRAME_CNT_EN adds a 16-bit wrapping frame counter output.
module pixel_seq_ctrl #(
    parameter int ROWS    = 4,
    parameter int COLUMNS = 4,
    parameter int CNT_W   = 8,
    localparam int P      = ROWS * COLUMNS,
    localparam int ADDR_W = (P > 1) ? $clog2(P) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [CNT_W-1:0]  cfg_wdata,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    input  logic              sink_ready,
    output logic              busy,
    output logic              erase,
    output logic              expose,
    output logic              convert,
    output logic              read,
    output logic [ADDR_W-1:0] pixeladdr,
    output logic              sample,
`ifdef PIXEL_SEQ_FRAME_CNT_EN
    output logic [15:0]       frame_cnt,
`endif
    output logic              frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_DONE, S_WAIT
    } state_t;

    // Index order: 0=erase, 1=expose, 2=convert, 3=read
    localparam logic [3:0][CNT_W-1:0] CFG_DEFAULT =
        {CNT_W'(5), CNT_W'(255), CNT_W'(255), CNT_W'(5)};

    state_t                  state, state_nxt;
    logic [3:0][CNT_W-1:0]   live_cfg, live_nxt, shadow_cfg;
    logic [CNT_W-1:0]        cnt, cnt_nxt, cur_dur;
    logic [ADDR_W-1:0]       addr, addr_nxt;
    logic                    stop_pending, stop_pending_nxt;
    logic                    phase_end;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_nxt = state;
        cnt_nxt   = '0;
        addr_nxt  = '0;
        live_nxt  = live_cfg;
        if (cfg_we)
            live_nxt[cfg_addr] = cfg_wdata;

        case (state)
            S_ERASE:   cur_dur = shadow_cfg[0];
            S_EXPOSE:  cur_dur = shadow_cfg[1];
            S_CONVERT: cur_dur = shadow_cfg[2];
            S_READ:    cur_dur = shadow_cfg[3];
            default:   cur_dur = '0;
        endcase
        phase_end = (cnt == cur_dur);

        case (state)
            S_IDLE: if (start) state_nxt = S_ERASE;
            S_ERASE, S_EXPOSE, S_CONVERT: begin
                if (phase_end) begin
                    case (state)
                        S_ERASE:  state_nxt = S_EXPOSE;
                        S_EXPOSE: state_nxt = S_CONVERT;
                        default:  state_nxt = S_READ;
                    endcase
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_READ: begin
                addr_nxt = addr;
                if (!phase_end)
                    cnt_nxt = cnt + CNT_W'(1);
                else if (addr == ADDR_W'(P - 1)) begin
                    state_nxt = S_DONE;
                    addr_nxt  = '0;
                end else
                    addr_nxt = addr + ADDR_W'(1);
            end
            S_DONE: begin
                if (!continuous || stop_pending) state_nxt = S_IDLE;
                else if (sink_ready)             state_nxt = S_ERASE;
                else                             state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (stop)            state_nxt = S_IDLE;
                else if (sink_ready) state_nxt = S_ERASE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // A stop seen together with the start that launches a frame still ends the run after it.
        stop_pending_nxt = (state_nxt == S_IDLE) ? 1'b0 : (stop_pending | stop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            addr         <= '0;
            stop_pending <= 1'b0;
            // NOTE: the config registers are a tiny register file with defined power-on values, so they are reset like ordinary flops.
            live_cfg     <= CFG_DEFAULT;
            shadow_cfg   <= CFG_DEFAULT;
            busy         <= 1'b0;
            erase        <= 1'b0;
            expose       <= 1'b0;
            convert      <= 1'b0;
            read         <= 1'b0;
            pixeladdr    <= '0;
            sample       <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            addr         <= addr_nxt;
            stop_pending <= stop_pending_nxt;
            live_cfg     <= live_nxt;
            if (state_nxt == S_ERASE && state != S_ERASE)
                shadow_cfg <= live_nxt;
            busy         <= (state_nxt != S_IDLE);
            erase        <= (state_nxt == S_ERASE);
            expose       <= (state_nxt == S_EXPOSE);
            convert      <= (state_nxt == S_CONVERT);
            read         <= (state_nxt == S_READ);
            pixeladdr    <= addr_nxt;
            sample       <= (state_nxt == S_READ) && (cnt_nxt == shadow_cfg[3]);
            frame_done   <= (state_nxt == S_DONE);
        end
    end

`ifdef PIXEL_SEQ_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            frame_cnt <= '0;
        else if (frame_done)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Self-checking bench for pixel_seq_ctrl: directed scenarios plus randomized frames
// compared cycle by cycle against an arithmetic frame-timeline model.
module tb_pixel_seq_ctrl;

    localparam int ROWS    = 4;
    localparam int COLUMNS = 4;
    localparam int CNT_W   = 8;
    localparam int P       = ROWS * COLUMNS;
    localparam int AW      = 4;
    localparam int VW      = AW + 7;
    localparam logic [VW-1:0] V_IDLE = '0;
    localparam logic [VW-1:0] V_WAIT = VW'(1) << (VW - 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_addr = '0;
    logic [CNT_W-1:0] cfg_wdata = '0;
    logic             start = 1'b0;
    logic             continuous = 1'b0;
    logic             stop = 1'b0;
    logic             sink_ready = 1'b0;
    logic             busy, erase, expose, convert, read, sample, frame_done;
    logic [AW-1:0]    pixeladdr;
`ifdef PIXEL_SEQ_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
`endif
    logic [VW-1:0]    obs;

    int assertions = 0;
    int failures   = 0;
    int live [4];

    pixel_seq_ctrl #(.ROWS(ROWS), .COLUMNS(COLUMNS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start), .continuous(continuous), .stop(stop), .sink_ready(sink_ready),
        .busy(busy), .erase(erase), .expose(expose), .convert(convert), .read(read),
        .pixeladdr(pixeladdr), .sample(sample),
`ifdef PIXEL_SEQ_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    assign obs = {busy, erase, expose, convert, read, sample, frame_done, pixeladdr};

    function automatic int frame_len(input int e, input int x, input int c, input int r);
        return (e + 1) + (x + 1) + (c + 1) + P * (r + 1) + 1;
    endfunction

    // Expected outputs at cycle k of a frame, counted from the first erase cycle.
    function automatic logic [VW-1:0] exp_vec(input int k, input int e, input int x,
                                              input int c, input int r);
        int t0 = e + 1;
        int t1 = t0 + x + 1;
        int t2 = t1 + c + 1;
        int t3 = t2 + P * (r + 1);
        logic er = 1'b0, ex = 1'b0, cv = 1'b0, rd = 1'b0, sm = 1'b0, fd = 1'b0;
        logic [AW-1:0] a = '0;
        if (k < t0)      er = 1'b1;
        else if (k < t1) ex = 1'b1;
        else if (k < t2) cv = 1'b1;
        else if (k < t3) begin
            rd = 1'b1;
            a  = AW'((k - t2) / (r + 1));
            sm = ((k - t2) % (r + 1)) == r;
        end else
            fd = 1'b1;
        return {1'b1, er, ex, cv, rd, sm, fd, a};
    endfunction

    task automatic check(input string tag, input int k, input logic [VW-1:0] expected);
        assertions++;
        assert (obs === expected) else begin
            failures++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, k, obs, expected);
        end
    endtask

    task automatic clear_pulses();
        cfg_we = 1'b0;
        stop   = 1'b0;
        start  = 1'b0;
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clear_pulses();
            check(tag, i, V_IDLE);
        end
    endtask

    task automatic wait_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clear_pulses();
            check(tag, i, V_WAIT);
        end
    endtask

    task automatic idle_cfg(input int a, input int d);
        cfg_we    = 1'b1;
        cfg_addr  = 2'(a);
        cfg_wdata = CNT_W'(d);
        live[a]   = d;
        idle_cycles("cfg_idle", 1);
    endtask

    // act: 0 none, 1 config write, 2 stop pulse, 3 assert reset and leave, 4 start pulse
    task automatic check_frame(input string tag, input int e, input int x, input int c,
                               input int r, input int act_k, input int act,
                               input int aa, input int ad);
        int len = frame_len(e, x, c, r);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            clear_pulses();
            check(tag, k, exp_vec(k, e, x, c, r));
            if (k == act_k) begin
                case (act)
                    1: begin
                        cfg_we    = 1'b1;
                        cfg_addr  = 2'(aa);
                        cfg_wdata = CNT_W'(ad);
                        live[aa]  = ad;
                    end
                    2: stop = 1'b1;
                    3: begin
                        rst = 1'b1;
                        return;
                    end
                    4: start = 1'b1;
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        int len, rk, ra, rd;
        live = '{5, 255, 255, 5};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset", 0, V_IDLE);
        rst = 1'b0;
        idle_cycles("after_reset", 2);

        // Default durations, single shot
        start = 1'b1;
        check_frame("default_frame", 5, 255, 255, 5, -1, 0, 0, 0);
        idle_cycles("default_end", 2);

        // Short programmed durations
        idle_cfg(0, 0); idle_cfg(1, 2); idle_cfg(2, 3); idle_cfg(3, 1);
        start = 1'b1;
        check_frame("short_frame", 0, 2, 3, 1, -1, 0, 0, 0);
        idle_cycles("short_end", 2);

        // Write during EXPOSE affects only the next frame; stop mid-CONVERT ends the run
        idle_cfg(0, 0); idle_cfg(1, 255); idle_cfg(2, 0); idle_cfg(3, 0);
        continuous = 1'b1; sink_ready = 1'b1;
        start = 1'b1;
        check_frame("shadow_f1", 0, 255, 0, 0, 10, 1, 1, 10);
        check_frame("shadow_f2", live[0], live[1], live[2], live[3], 12, 2, 0, 0);
        idle_cycles("stop_end", 3);

        // Back-pressure: WAIT until sink_ready, then stop in the resumed frame
        sink_ready = 1'b0;
        start = 1'b1;
        check_frame("bp_f1", live[0], live[1], live[2], live[3], -1, 0, 0, 0);
        wait_cycles("bp_wait", 3);
        sink_ready = 1'b1;
        check_frame("bp_f2", live[0], live[1], live[2], live[3], 0, 2, 0, 0);
        idle_cycles("bp_end", 2);

        // Stop while in WAIT
        sink_ready = 1'b0;
        start = 1'b1;
        check_frame("wstop_f", live[0], live[1], live[2], live[3], -1, 0, 0, 0);
        wait_cycles("wstop_wait", 2);
        stop = 1'b1;
        idle_cycles("wstop_end", 3);

        // start while busy is ignored
        continuous = 1'b0; sink_ready = 1'b1;
        start = 1'b1;
        check_frame("busy_start", live[0], live[1], live[2], live[3], 3, 4, 0, 0);
        idle_cycles("busy_start_end", 3);

        // start and stop together give exactly one frame
        continuous = 1'b1;
        start = 1'b1; stop = 1'b1;
        check_frame("start_stop", live[0], live[1], live[2], live[3], -1, 0, 0, 0);
        idle_cycles("start_stop_end", 3);

        // Write in DONE lands in the shadow copy of the following frame
        start = 1'b1;
        len = frame_len(live[0], live[1], live[2], live[3]);
        check_frame("wt_f1", live[0], live[1], live[2], live[3], len - 1, 1, 0, 3);
        check_frame("wt_f2", live[0], live[1], live[2], live[3], 0, 2, 0, 0);
        idle_cycles("wt_end", 2);

        // Randomized frames with a mid-frame config write
        for (int it = 0; it < 6; it++) begin
            idle_cfg(0, $urandom_range(0, 6));
            idle_cfg(1, $urandom_range(0, 6));
            idle_cfg(2, $urandom_range(0, 6));
            idle_cfg(3, $urandom_range(0, 2));
            continuous = 1'($urandom_range(0, 1));
            sink_ready = 1'b1;
            len = frame_len(live[0], live[1], live[2], live[3]);
            rk  = $urandom_range(0, len - 1);
            ra  = $urandom_range(0, 3);
            rd  = $urandom_range(0, 2);
            start = 1'b1;
            if (continuous) begin
                check_frame("rand_f1", live[0], live[1], live[2], live[3], rk, 1, ra, rd);
                check_frame("rand_f2", live[0], live[1], live[2], live[3], 0, 2, 0, 0);
            end else
                check_frame("rand_f", live[0], live[1], live[2], live[3], rk, 1, ra, rd);
            idle_cycles("rand_end", 2);
        end

        // Reset during READ at pixel 7, then defaults are back
        continuous = 1'b0;
        idle_cfg(0, 1); idle_cfg(1, 2); idle_cfg(2, 1); idle_cfg(3, 0);
        start = 1'b1;
        check_frame("pre_reset", 1, 2, 1, 0, 14, 3, 0, 0);
        @(negedge clk);
        check("mid_reset", 0, V_IDLE);
        rst = 1'b0;
        live = '{5, 255, 255, 5};
        idle_cycles("post_reset", 1);
        start = 1'b1;
        check_frame("post_reset_frame", 5, 255, 255, 5, -1, 0, 0, 0);
        idle_cycles("final", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
